// File: rtl/aes_stream_wrapper.sv
// Packs a 32-bit word stream into AES-128 blocks, tracks them through the fixed-latency core, unpacks ciphertext.
// Latency: the last input word to the first output word is CORE_LAT+1 cycles (issue edge + CORE_LAT edges to buffer write).
// Backpressure: the core cannot stall, so the 4th word of a block is held off (s_ready=0) until a buffer credit is free.
//
// Ports:
//   clk, rst_n                    clock (rising edge) and asynchronous active-low reset
//   key_in, key_load              cipher key and its one-cycle load strobe (honoured only when idle)
//   key_busy, key_err             key settling (input stalled) / sticky rejected-load flag
//   s_data, s_valid, s_ready      32-bit input word stream, valid/ready handshake
//   m_data, m_valid, m_ready      32-bit output word stream, valid/ready handshake
//   core_data_in, core_key        registered plaintext block and key to the AES core
//   core_data_out                 ciphertext block from the AES core
module aes_stream_wrapper #(
    parameter int CORE_LAT = 10,
    parameter int KEY_LAT  = 10,
    parameter int DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] key_in,
    input  logic         key_load,
    output logic         key_busy,
    output logic         key_err,
    input  logic [0:31]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [0:31]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [0:127] core_data_in,
    output logic [0:127] core_key,
    input  logic [0:127] core_data_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW = $clog2(KEY_LAT + 1);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [KW-1:0] KEY_CNT    = KW'(KEY_LAT);

    // Input packer state: words 0..2 are staged, word 3 goes straight into core_data_in.
    logic [1:0]          wcnt;
    logic [0:95]         stage;

    // Credits cover both in-flight tags and buffered blocks, so a block is only
    // issued when the buffer is guaranteed to have room when it emerges.
    logic [CW-1:0]       credit;
    logic [CORE_LAT-1:0] tag;

    // Output block buffer and unpacker state.
    logic [0:127]        buf_mem [DEPTH];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [CW-1:0]       fcnt;
    logic [1:0]          rcnt;
    logic [0:127]        head;

    // Key settle down-counter.
    logic [KW-1:0]       kcnt;

    logic idle;
    logic key_accept;
    logic s_fire;
    logic issue;
    logic buf_wr;
    logic m_fire;
    logic pop;

    assign idle       = (wcnt == 2'd0) && (credit == '0);
    assign key_busy   = (kcnt != '0);
    assign key_accept = key_load && idle && !key_busy;

    // A key load that lands while idle wins over an input word in the same cycle.
    assign s_ready = !key_busy && !(key_load && idle) &&
                     ((wcnt != 2'd3) || (credit < CREDIT_MAX));
    assign s_fire  = s_valid && s_ready;
    assign issue   = s_fire && (wcnt == 2'd3);

    // The tag that entered with a block reaches the last stage exactly when
    // the core presents that block's ciphertext.
    assign buf_wr  = tag[CORE_LAT-1];

    assign m_valid = (fcnt != '0);
    assign m_fire  = m_valid && m_ready;
    assign pop     = m_fire && (rcnt == 2'd3);

    assign head    = buf_mem[rptr];
    assign m_data  = head[{rcnt, 5'd0} +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt         <= '0;
            stage        <= '0;
            core_data_in <= '0;
            core_key     <= '0;
            credit       <= '0;
            tag          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            fcnt         <= '0;
            rcnt         <= '0;
            kcnt         <= '0;
            key_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            tag <= {tag[CORE_LAT-2:0], issue};

            if (s_fire) begin
                if (wcnt == 2'd3) begin
                    core_data_in <= {stage, s_data};
                end else begin
                    stage[{wcnt, 5'd0} +: 32] <= s_data;
                end
                wcnt <= wcnt + 2'd1;
            end

            if (issue && !pop) begin
                credit <= credit + CW'(1);
            end else if (!issue && pop) begin
                credit <= credit - CW'(1);
            end

            if (buf_wr) begin
                buf_mem[wptr] <= core_data_out;
                wptr          <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            end

            if (m_fire) begin
                rcnt <= rcnt + 2'd1;
                if (rcnt == 2'd3) begin
                    rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
                end
            end

            if (buf_wr && !pop) begin
                fcnt <= fcnt + CW'(1);
            end else if (!buf_wr && pop) begin
                fcnt <= fcnt - CW'(1);
            end

            if (key_accept) begin
                core_key <= key_in;
                kcnt     <= KEY_CNT;
            end else if (kcnt != '0) begin
                kcnt <= kcnt - KW'(1);
            end

            if (key_load && !key_accept) begin
                key_err <= 1'b1;
            end
        end
    end

endmodule
